// File: rtl/dff_bank_arbiter.sv
// Round-robin controller that shares a bank of D flip-flop cells between requesters A and B,
// sequencing each load/preset/clear/read through GRANT, APPLY and CHECK and verifying the result.
module dff_bank_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [1:0]       op_a,
  input  logic [1:0]       op_b,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             done_a,
  output logic             done_b,
  output logic             err,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic [WIDTH-1:0] ff_d,
  output logic [WIDTH-1:0] ff_pre,
  output logic [WIDTH-1:0] ff_clr,
  input  logic [WIDTH-1:0] ff_q
);

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_PRESET = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_GRANT = 2'b01,
    S_APPLY = 2'b10,
    S_CHECK = 2'b11
  } state_t;

  state_t           r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_exp;
  logic             r_id;
  logic             r_last_b;
  logic             r_err;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_gnt_a;
  logic             r_gnt_b;
  logic             r_done_a;
  logic             r_done_b;

  logic             w_win_b;
  logic             w_apply;

  // Value the cells must hold after APPLY; READ expects the contents seen on entry to APPLY.
  function automatic logic [WIDTH-1:0] f_expected(input logic [1:0]       op,
                                                  input logic [WIDTH-1:0] data,
                                                  input logic [WIDTH-1:0] q);
    case (op)
      OP_LOAD:   f_expected = data;
      OP_PRESET: f_expected = {WIDTH{1'b1}};
      OP_CLEAR:  f_expected = '0;
      default:   f_expected = q;
    endcase
  endfunction

  // On a tie the requester that did not win last time takes the grant.
  assign w_win_b = req_b & (~req_a | ~r_last_b);
  assign w_apply = (r_state == S_APPLY);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state   <= S_IDLE;
      r_op      <= OP_LOAD;
      r_data    <= '0;
      r_exp     <= '0;
      r_id      <= 1'b0;
      r_last_b  <= 1'b1;
      r_err     <= 1'b0;
      r_rd_data <= '0;
      r_gnt_a   <= 1'b0;
      r_gnt_b   <= 1'b0;
      r_done_a  <= 1'b0;
      r_done_b  <= 1'b0;
    end else begin
      r_gnt_a  <= 1'b0;
      r_gnt_b  <= 1'b0;
      r_done_a <= 1'b0;
      r_done_b <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_a || req_b) begin
            r_state  <= S_GRANT;
            r_id     <= w_win_b;
            r_last_b <= w_win_b;
            r_op     <= w_win_b ? op_b : op_a;
            r_data   <= w_win_b ? data_b : data_a;
            r_gnt_a  <= ~w_win_b;
            r_gnt_b  <= w_win_b;
          end
        end
        S_GRANT: begin
          r_state <= S_APPLY;
          r_exp   <= f_expected(r_op, r_data, ff_q);
        end
        S_APPLY: r_state <= S_CHECK;
        S_CHECK: begin
          r_state   <= S_IDLE;
          r_rd_data <= ff_q;
          r_err     <= (ff_q != r_exp);
          r_done_a  <= ~r_id;
          r_done_b  <= r_id;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Cells capture d on every edge, so outside a LOAD in APPLY they recirculate their own output.
  always_comb begin
    ff_pre = '0;
    ff_clr = '0;
    ff_d   = ff_q;
    if (w_apply) begin
      case (r_op)
        OP_LOAD:   ff_d   = r_data;
        OP_PRESET: ff_pre = {WIDTH{1'b1}};
        OP_CLEAR:  ff_clr = {WIDTH{1'b1}};
        default:   ff_d   = ff_q;
      endcase
    end
  end

  assign gnt_a   = r_gnt_a;
  assign gnt_b   = r_gnt_b;
  assign done_a  = r_done_a;
  assign done_b  = r_done_b;
  assign err     = r_err;
  assign rd_data = r_rd_data;
  assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Bench for dff_bank_arbiter: models the flip-flop cell array and predicts each operation's
// outcome from the operation semantics alone.
module tb_dff_bank_arbiter;
  logic       clk = 1'b0;
  logic       clr;
  logic       req_a, req_b;
  logic [1:0] op_a, op_b;
  logic [7:0] data_a, data_b;
  logic       gnt_a, gnt_b, done_a, done_b, err, busy;
  logic [7:0] rd_data, ff_d, ff_pre, ff_clr, ff_q;

  logic [7:0] cell_q = 8'h00;
  logic [7:0] stuck  = 8'h00;
  logic [7:0] model_obs = 8'h00;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Cell array: synchronous clear/preset, otherwise capture d; stuck bits read as 0.
  always @(posedge clk) cell_q <= (ff_d | ff_pre) & ~ff_clr;
  assign ff_q = cell_q & ~stuck;

  dff_bank_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .clr(clr), .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
    .data_a(data_a), .data_b(data_b), .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a),
    .done_b(done_b), .err(err), .rd_data(rd_data), .busy(busy), .ff_d(ff_d),
    .ff_pre(ff_pre), .ff_clr(ff_clr), .ff_q(ff_q)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] intended(input logic [1:0] op, input logic [7:0] d,
                                          input logic [7:0] cur);
    case (op)
      2'b00:   return d;
      2'b01:   return 8'hFF;
      2'b10:   return 8'h00;
      default: return cur;
    endcase
  endfunction

  task automatic do_op(input logic who, input logic [1:0] op, input logic [7:0] d, input string name);
    logic [7:0] want, obs;
    logic got_g, got_d;
    want  = intended(op, d, model_obs);
    obs   = want & ~stuck;
    got_g = 1'b0;
    got_d = 1'b0;
    if (!who) begin req_a = 1'b1; op_a = op; data_a = d; end
    else      begin req_b = 1'b1; op_b = op; data_b = d; end
    for (int i = 1; i <= 8 && !got_g; i++) begin
      tick;
      got_g = who ? gnt_b : gnt_a;
      if (got_g) begin
        checks++;
        if (i != 1 || (who ? gnt_a : gnt_b) !== 1'b0 || busy !== 1'b1) begin
          failures++;
          $display("FAIL %s grant: cycles=%0d other_gnt=%b busy=%b, required cycles=1 other_gnt=0 busy=1",
                   name, i, who ? gnt_a : gnt_b, busy);
        end
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    op_a = 2'($urandom); op_b = 2'($urandom); data_a = 8'($urandom); data_b = 8'($urandom);
    if (!got_g) begin
      checks++; failures++;
      $display("FAIL %s grant timeout: no gnt within 8 cycles", name);
      return;
    end
    for (int c = 1; c <= 8 && !got_d; c++) begin
      tick;
      if (c == 2) begin
        checks++;
        if (ff_q !== obs) begin
          failures++;
          $display("FAIL %s cells after apply: ff_q=%h required=%h", name, ff_q, obs);
        end
      end
      got_d = who ? done_b : done_a;
      if (got_d) begin
        checks++;
        if (c != 3) begin
          failures++;
          $display("FAIL %s done latency: cycles_after_gnt=%0d required=3", name, c);
        end
      end
    end
    if (!got_d) begin
      checks++; failures++;
      $display("FAIL %s done timeout: no done within 8 cycles", name);
      return;
    end
    checks++;
    if (err !== (obs != want) || rd_data !== obs || busy !== 1'b0 || (who ? done_a : done_b) !== 1'b0) begin
      failures++;
      $display("FAIL %s result: err=%b rd_data=%h busy=%b other_done=%b, required err=%b rd_data=%h busy=0 other_done=0",
               name, err, rd_data, busy, who ? done_a : done_b, (obs != want), obs);
    end
    model_obs = obs;
  endtask

  task automatic test_reset;
    clr = 1'b1; req_a = 1'b0; req_b = 1'b0;
    op_a = 2'b00; op_b = 2'b00; data_a = 8'h00; data_b = 8'h00;
    tick; tick;
    checks++;
    if ({gnt_a, gnt_b, done_a, done_b, busy, err} !== 6'b0 || rd_data !== 8'h00 ||
        ff_pre !== 8'h00 || ff_clr !== 8'h00 || ff_d !== model_obs) begin
      failures++;
      $display("FAIL reset state: ctl=%b rd=%h pre=%h clr=%h d=%h, required ctl=0 rd=00 pre=00 clr=00 d=%h",
               {gnt_a, gnt_b, done_a, done_b, busy, err}, rd_data, ff_pre, ff_clr, ff_d, model_obs);
    end
    clr = 1'b0;
  endtask

  task automatic test_load_basic;
    do_op(1'b0, 2'b00, 8'hA5, "load_a5");
  endtask

  task automatic test_back_to_back;
    logic q_owner[$];
    logic exp_owner, owner, last_owner;
    int last_cyc, n;
    exp_owner = 1'b0; last_owner = 1'b0; last_cyc = 0; n = 0;
    clr = 1'b1;
    tick;
    req_a = 1'b1; req_b = 1'b1; op_a = 2'b00; op_b = 2'b00; data_a = 8'h11; data_b = 8'h22;
    tick;
    clr = 1'b0;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      tick;
      if (gnt_a || gnt_b) begin
        checks++;
        if ((gnt_a && gnt_b) || gnt_b !== exp_owner || (n == 0 && cyc != 1) || (n > 0 && cyc - last_cyc != 4)) begin
          failures++;
          $display("FAIL b2b grant %0d: gnt_a=%b gnt_b=%b cycle=%0d, required owner=%b spacing 4 from %0d",
                   n, gnt_a, gnt_b, cyc, exp_owner, last_cyc);
        end
        q_owner.push_back(gnt_b);
        last_owner = gnt_b;
        exp_owner = ~exp_owner;
        last_cyc = cyc;
        n++;
      end
      if (done_a || done_b) begin
        owner = done_b;
        checks++;
        if (q_owner.size() == 0 || owner !== q_owner[0] || rd_data !== (owner ? 8'h22 : 8'h11) || err !== 1'b0) begin
          failures++;
          $display("FAIL b2b done: owner=%b rd_data=%h err=%b, required owner=%b rd_data=%h err=0",
                   owner, rd_data, err, q_owner.size() ? q_owner[0] : 1'bx,
                   (owner ? 8'h22 : 8'h11));
        end
        if (q_owner.size() != 0) void'(q_owner.pop_front());
      end
      if (cyc == 14) begin req_a = 1'b0; req_b = 1'b0; end
    end
    checks++;
    if (n != 4 || q_owner.size() != 0) begin
      failures++;
      $display("FAIL b2b count: grants=%0d outstanding=%0d, required grants=4 outstanding=0", n, q_owner.size());
    end
    model_obs = last_owner ? 8'h22 : 8'h11;
  endtask

  task automatic test_preset_clear_read;
    do_op(1'b1, 2'b01, 8'h00, "preset_b");
    do_op(1'b1, 2'b10, 8'h00, "clear_b");
    do_op(1'b1, 2'b11, 8'h00, "read_b");
  endtask

  task automatic test_idle_hold;
    do_op(1'b0, 2'b00, 8'h3C, "load_3c");
    for (int i = 0; i < 20; i++) begin
      tick;
      checks++;
      if ({ff_q, ff_pre, ff_clr, ff_d} !== {8'h3C, 8'h00, 8'h00, 8'h3C}) begin
        failures++;
        $display("FAIL idle hold cycle %0d: q=%h pre=%h clr=%h d=%h, required q=3c pre=00 clr=00 d=3c",
                 i, ff_q, ff_pre, ff_clr, ff_d);
      end
    end
  endtask

  task automatic test_stuck;
    stuck = 8'h01;
    do_op(1'b0, 2'b00, 8'h01, "stuck_load");
    stuck = 8'h00;
    tick;
  endtask

  task automatic test_mid_apply_reset;
    do_op(1'b0, 2'b00, 8'h5A, "load_5a");
    req_a = 1'b1; op_a = 2'b10;
    tick;
    req_a = 1'b0;
    checks++;
    if (gnt_a !== 1'b1) begin
      failures++;
      $display("FAIL clear grant: gnt_a=%b required=1", gnt_a);
    end
    tick;
    checks++;
    if (ff_clr !== 8'hFF) begin
      failures++;
      $display("FAIL apply clear drive: ff_clr=%h required=ff", ff_clr);
    end
    #2 clr = 1'b1;
    #1;
    checks++;
    if ({gnt_a, gnt_b, done_a, done_b, busy, err} !== 6'b0 || rd_data !== 8'h00 ||
        ff_clr !== 8'h00 || ff_pre !== 8'h00 || ff_d !== 8'h5A) begin
      failures++;
      $display("FAIL async reset: ctl=%b rd=%h clr=%h pre=%h d=%h, required ctl=0 rd=00 clr=00 pre=00 d=5a",
               {gnt_a, gnt_b, done_a, done_b, busy, err}, rd_data, ff_clr, ff_pre, ff_d);
    end
    for (int i = 0; i < 6; i++) begin
      tick;
      if (i == 2) clr = 1'b0;
      checks++;
      if (ff_q !== 8'h5A || done_a !== 1'b0 || done_b !== 1'b0) begin
        failures++;
        $display("FAIL post reset hold %0d: ff_q=%h done=%b%b, required ff_q=5a done=00",
                 i, ff_q, done_a, done_b);
      end
    end
    do_op(1'b0, 2'b11, 8'h00, "read_after_reset");
  endtask

  task automatic test_random;
    logic who;
    logic [1:0] op;
    logic [7:0] d;
    for (int i = 0; i < 16; i++) begin
      who = 1'($urandom_range(0, 1));
      op  = 2'($urandom_range(0, 3));
      d   = 8'($urandom);
      do_op(who, op, d, "random");
    end
  endtask

  initial begin
    test_reset;
    test_load_basic;
    test_back_to_back;
    test_preset_clear_read;
    test_idle_hold;
    test_stuck;
    test_mid_apply_reset;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
